// File: rtl/gpmc_bridge_pkg.sv
// Shared types and constants for the GPMC register-file bridge.
package gpmc_bridge_pkg;

   localparam int unsigned BUS_WIDTH  = 16;
   localparam int unsigned CTRL_WIDTH = 4;
   localparam int unsigned BE_WIDTH   = 2;
   localparam int unsigned SYNC_WIDTH = CTRL_WIDTH + BE_WIDTH + BUS_WIDTH;

   // Idle levels the synchronisers flush to: controls deasserted, bus low.
   localparam logic [CTRL_WIDTH-1:0] CTRL_IDLE = '1;
   localparam logic [BE_WIDTH-1:0]   BE_IDLE   = '1;
   localparam logic [BUS_WIDTH-1:0]  AD_IDLE   = '0;
   localparam logic [SYNC_WIDTH-1:0] SYNC_IDLE = {CTRL_IDLE, BE_IDLE, AD_IDLE};

   typedef enum logic [1:0] {
      StIdle,
      StAddr,
      StWrite,
      StRead
   } state_e;

endpackage

// File: rtl/gpmc_regfile_bridge_if.sv
// GPMC pad-side signals: split in/out/oe for the SB_IO buffer plus raw controls.
interface gpmc_regfile_bridge_if;
   import gpmc_bridge_pkg::*;

   logic [BUS_WIDTH-1:0] gpmc_ad_in;
   logic [BUS_WIDTH-1:0] gpmc_ad_out;
   logic                 gpmc_ad_oe;
   logic                 gpmc_csn1;
   logic                 gpmc_advn;
   logic                 gpmc_wein;
   logic                 gpmc_oen;
   logic [BE_WIDTH-1:0]  gpmc_be_n;

   // Host side: drives the pins, observes read data and enable.
   modport master (
      output gpmc_ad_in, gpmc_csn1, gpmc_advn, gpmc_wein, gpmc_oen, gpmc_be_n,
      input  gpmc_ad_out, gpmc_ad_oe
   );

   // Bridge side.
   modport slave (
      input  gpmc_ad_in, gpmc_csn1, gpmc_advn, gpmc_wein, gpmc_oen, gpmc_be_n,
      output gpmc_ad_out, gpmc_ad_oe
   );

endinterface

// File: rtl/gpmc_sync.sv
// Multi-stage synchroniser with a configurable synchronous reset value.
module gpmc_sync #(
   parameter int unsigned      WIDTH     = 1,
   parameter int unsigned      STAGES    = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [STAGES-1:0][WIDTH-1:0] r_stage;

   // Shift the async input through STAGES flops; reset flushes to idle level.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stage <= {STAGES{RESET_VAL}};
      end else begin
         r_stage <= {r_stage[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/gpmc_regfile_bridge.sv
// GPMC slave on the system clock: synchronised bus sampling, phase-decoding FSM,
// control register bank and read mux over control registers and status inputs.
module gpmc_regfile_bridge
   import gpmc_bridge_pkg::*;
#(
   parameter int unsigned  ADDR_WIDTH  = 4,
   parameter int unsigned  RO_BASE     = 8,
   parameter int unsigned  SYNC_STAGES = 2,
   localparam int unsigned NUM_REGS    = 2 ** ADDR_WIDTH,
   localparam int unsigned NUM_RO      = NUM_REGS - RO_BASE
) (
   input  logic                          clk,
   input  logic                          rst,
   gpmc_regfile_bridge_if.slave          io_gpmc,
   output logic [RO_BASE*BUS_WIDTH-1:0]  o_reg_out,
   input  logic [NUM_RO*BUS_WIDTH-1:0]   i_status_in,
   output logic [NUM_REGS-1:0]           o_wr_strobe,
   output logic [NUM_REGS-1:0]           o_rd_strobe
);

   logic [SYNC_WIDTH-1:0]         w_raw;
   logic [SYNC_WIDTH-1:0]         w_sync;
   logic                          w_csn1_s;
   logic                          w_advn_s;
   logic                          w_wein_s;
   logic                          w_oen_s;
   logic [BE_WIDTH-1:0]           w_be_n_s;
   logic [BUS_WIDTH-1:0]          w_ad_s;
   logic [BUS_WIDTH-1:0]          w_rd_data;

   state_e                        r_state;
   logic [ADDR_WIDTH-1:0]         r_addr;
   logic [BUS_WIDTH-1:0]          r_hold_data;
   logic [BE_WIDTH-1:0]           r_hold_be;
   logic [BUS_WIDTH-1:0]          r_data;
   logic                          r_oe;
   logic [RO_BASE*BUS_WIDTH-1:0]  r_regs;
   logic [NUM_REGS-1:0]           r_wr_strobe;
   logic [NUM_REGS-1:0]           r_rd_strobe;

   assign w_raw = {io_gpmc.gpmc_csn1, io_gpmc.gpmc_advn, io_gpmc.gpmc_wein, io_gpmc.gpmc_oen,
                   io_gpmc.gpmc_be_n, io_gpmc.gpmc_ad_in};

   gpmc_sync #(
      .WIDTH     (SYNC_WIDTH),
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (SYNC_IDLE)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d (w_raw),
      .o_q (w_sync)
   );

   assign {w_csn1_s, w_advn_s, w_wein_s, w_oen_s, w_be_n_s, w_ad_s} = w_sync;

   // Read mux: control registers below RO_BASE, status inputs above.
   always_comb begin
      w_rd_data = '0;
      for (int unsigned i = 0; i < RO_BASE; i++) begin
         if (r_addr == ADDR_WIDTH'(i)) w_rd_data = r_regs[BUS_WIDTH*i +: BUS_WIDTH];
      end
      for (int unsigned i = 0; i < NUM_RO; i++) begin
         if (r_addr == ADDR_WIDTH'(RO_BASE + i)) w_rd_data = i_status_in[BUS_WIDTH*i +: BUS_WIDTH];
      end
   end

   // Phase-decoding FSM with registered data, enable, strobes and register bank.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= StIdle;
         r_addr      <= '0;
         r_hold_data <= '0;
         r_hold_be   <= BE_IDLE;
         r_data      <= '0;
         r_oe        <= 1'b0;
         r_regs      <= '0;
         r_wr_strobe <= '0;
         r_rd_strobe <= '0;
      end else begin
         r_wr_strobe <= '0;
         r_rd_strobe <= '0;
         if (w_csn1_s) begin
            // Chip deselect aborts anything in flight, including a pending write.
            r_state <= StIdle;
            r_oe    <= 1'b0;
         end else if (!w_advn_s) begin
            r_addr  <= w_ad_s[ADDR_WIDTH-1:0];
            r_state <= StAddr;
            r_oe    <= 1'b0;
         end else begin
            unique case (r_state)
               StIdle: begin
                  r_oe <= 1'b0;
               end
               StAddr: begin
                  // Both strobes low is a protocol error: stay put, do nothing.
                  if (!w_wein_s && w_oen_s) begin
                     r_hold_data <= w_ad_s;
                     r_hold_be   <= w_be_n_s;
                     r_state     <= StWrite;
                  end else if (w_wein_s && !w_oen_s) begin
                     r_data      <= w_rd_data;
                     r_rd_strobe <= NUM_REGS'(1) << r_addr;
                     r_state     <= StRead;
                  end
               end
               StWrite: begin
                  if (!w_wein_s) begin
                     r_hold_data <= w_ad_s;
                     r_hold_be   <= w_be_n_s;
                  end else begin
                     // Rising wein commits the value held from the last low cycle.
                     for (int unsigned i = 0; i < RO_BASE; i++) begin
                        if (r_addr == ADDR_WIDTH'(i)) begin
                           for (int unsigned b = 0; b < BE_WIDTH; b++) begin
                              if (!r_hold_be[b]) begin
                                 r_regs[BUS_WIDTH*i + 8*b +: 8] <= r_hold_data[8*b +: 8];
                              end
                           end
                           r_wr_strobe[i] <= 1'b1;
                        end
                     end
                     r_state <= StAddr;
                  end
               end
               StRead: begin
                  if (w_oen_s) begin
                     r_oe    <= 1'b0;
                     r_state <= StAddr;
                  end else begin
                     r_oe <= 1'b1;
                  end
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   // Raw pins gate the enable so the bus is released without synchroniser delay.
   assign io_gpmc.gpmc_ad_oe  = r_oe & ~io_gpmc.gpmc_oen & ~io_gpmc.gpmc_csn1;
   assign io_gpmc.gpmc_ad_out = r_data;
   assign o_reg_out           = r_regs;
   assign o_wr_strobe         = r_wr_strobe;
   assign o_rd_strobe         = r_rd_strobe;

endmodule
